// File: rtl/fc_pkg.sv
// fc_pkg
// Shared definitions for the sequential fully connected neuron:
//   - fc_state_t : controller states (IDLE / ACC / OUT)
//   - acc_width  : default accumulator width for a given operand shape
//   - saturate / saturates : clamp a wide signed value into an out_w-bit
//     two's complement range and report whether clamping happened
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } fc_state_t;

    // Width of the working value handed to the saturation helpers.
    // Accumulators wider than this are not supported.
    localparam int SAT_W = 64;

    // Product width plus log2(N_IN) growth for the sum, plus one bit for the
    // zero-extended pixel sign and one bit of headroom for the bias.
    function automatic int acc_width(input int data_w, input int weight_w, input int n_in);
        return data_w + weight_w + $clog2(n_in) + 2;
    endfunction

    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] s,
                                                         input int out_w);
        logic signed [SAT_W-1:0] maxv;
        logic signed [SAT_W-1:0] minv;
        maxv = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (out_w - 1));
        if (s > maxv) begin
            return maxv;
        end else if (s < minv) begin
            return minv;
        end
        return s;
    endfunction

    function automatic logic saturates(input logic signed [SAT_W-1:0] s,
                                       input int out_w);
        logic signed [SAT_W-1:0] maxv;
        logic signed [SAT_W-1:0] minv;
        maxv = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        minv = -(64'sd1 <<< (out_w - 1));
        return (s > maxv) || (s < minv);
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane
// Purely combinational slice of the neuron datapath: LANES products of an
// unsigned pixel and a signed weight, summed into one ACC_W signed value.
// Ports:
//   pixels  : LANES unsigned pixels
//   weights : LANES two's complement weights
//   sum     : signed sum of the LANES products, ACC_W bits
module fc_mac_lane #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int LANES    = 2,
    parameter int ACC_W    = 21
) (
    input  logic [LANES-1:0][DATA_W-1:0]   pixels,
    input  logic [LANES-1:0][WEIGHT_W-1:0] weights,
    output logic signed [ACC_W-1:0]        sum
);

    logic signed [ACC_W-1:0] prod [LANES];

    // Each pixel gets a zero sign bit so the multiply is signed x signed, and
    // both operands are widened to ACC_W first so the product cannot wrap.
    always_comb begin
        sum = '0;
        for (int l = 0; l < LANES; l++) begin
            prod[l] = ACC_W'($signed({1'b0, pixels[l]})) * ACC_W'($signed(weights[l]));
            sum     = sum + prod[l];
        end
    end

endmodule

// File: rtl/fc_neuron_seq.sv
// fc_neuron_seq
// Multi-cycle fully connected neuron. Accepts a vector of N_IN pixels and
// weights plus a bias, accumulates LANES products per cycle over K=N_IN/LANES
// cycles, then shifts, optionally applies ReLU and saturates to OUT_W bits.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (pixels, weights, bias, shift, relu_en)
//   out_valid / out_ready: result handshake (result, overflow)
module fc_neuron_seq
    import fc_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int N_IN     = 8,
    parameter int LANES    = 2,
    parameter int OUT_W    = 8,
    parameter int ACC_W    = acc_width(DATA_W, WEIGHT_W, N_IN)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_IN-1:0][DATA_W-1:0]    pixels,
    input  logic [N_IN-1:0][WEIGHT_W-1:0]  weights,
    input  logic [OUT_W-1:0]               bias,
    input  logic [$clog2(ACC_W)-1:0]       shift,
    input  logic                           relu_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_W-1:0]               result,
    output logic                           overflow
);

    localparam int K     = N_IN / LANES;
    localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam int SH_W  = $clog2(ACC_W);

    fc_state_t                      state;
    logic [CNT_W-1:0]               cnt;
    logic signed [ACC_W-1:0]        acc;
    logic [N_IN-1:0][DATA_W-1:0]    pix_q;
    logic [N_IN-1:0][WEIGHT_W-1:0]  wt_q;
    logic [SH_W-1:0]                shift_q;
    logic                           relu_q;

    logic [LANES-1:0][DATA_W-1:0]   lane_pix;
    logic [LANES-1:0][WEIGHT_W-1:0] lane_wt;
    logic signed [ACC_W-1:0]        lane_sum;
    logic signed [ACC_W-1:0]        acc_final;
    logic signed [ACC_W-1:0]        acc_shifted;
    logic signed [ACC_W-1:0]        acc_relu;
    logic [OUT_W-1:0]               result_d;
    logic                           overflow_d;
    logic                           accept;
    logic                           last;

    // A new vector can enter while idle, or in the same cycle the current
    // result is taken, which gives back-to-back operation.
    assign in_ready = (state == IDLE) || ((state == OUT) && out_ready);
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == CNT_W'(K - 1));

    // Pick the LANES operands belonging to the current accumulation step.
    always_comb begin
        lane_pix = '0;
        lane_wt  = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_pix[l] = pix_q[int'(cnt) * LANES + l];
            lane_wt[l]  = wt_q[int'(cnt) * LANES + l];
        end
    end

    fc_mac_lane #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W),
        .LANES    (LANES),
        .ACC_W    (ACC_W)
    ) u_mac (
        .pixels   (lane_pix),
        .weights  (lane_wt),
        .sum      (lane_sum)
    );

    // Output stage works on the value the accumulator will hold after this
    // step, so the result is registered on the same edge as the last add.
    always_comb begin
        acc_final   = acc + lane_sum;
        acc_shifted = acc_final >>> shift_q;
        acc_relu    = (relu_q && acc_shifted[ACC_W-1]) ? '0 : acc_shifted;
        result_d    = OUT_W'(saturate(SAT_W'(acc_relu), OUT_W));
        overflow_d  = saturates(SAT_W'(acc_relu), OUT_W);
    end

    // Controller and datapath registers. Operands are captured on accept so
    // the producer may change its inputs straight away; out_valid and the
    // result only move on a completed output handshake or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            if (accept) begin
                pix_q   <= pixels;
                wt_q    <= weights;
                shift_q <= shift;
                relu_q  <= relu_en;
                acc     <= ACC_W'($signed(bias));
                cnt     <= '0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_final;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result    <= result_d;
                        overflow  <= overflow_d;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= accept ? ACC : IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_neuron_seq.sv
// tb_fc_neuron_seq
// Self-checking bench for fc_neuron_seq. Directed cases on the default
// configuration (LANES=2, N_IN=8), plus randomized vectors on LANES=1/N_IN=8
// and LANES=4/N_IN=16 instances compared against a plain-arithmetic model.
module tb_fc_neuron_seq;

    typedef logic [7:0][7:0] vec_t;

    localparam longint OUT_MAX = 127;
    localparam longint OUT_MIN = -128;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    vec_t       pixels;
    vec_t       weights;
    logic [7:0] bias;
    logic [4:0] shift;
    logic       relu_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;

    fc_neuron_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pixels    (pixels),
        .weights   (weights),
        .bias      (bias),
        .shift     (shift),
        .relu_en   (relu_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow)
    );

    // Free-running clock and edge counter used for latency measurement.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference neuron: bias plus dot product in plain integers, then
    // arithmetic shift, optional ReLU and clamp to the 8-bit signed range.
    function automatic void refModel(input longint pm[16], input longint wm[16], input int n,
                                     input longint b, input int sh, input bit re,
                                     output longint res, output bit ovf);
        longint s;
        s = b;
        for (int i = 0; i < n; i++) s += pm[i] * wm[i];
        s = s >>> sh;
        if (re && s < 0) s = 0;
        if (s > OUT_MAX) begin
            res = OUT_MAX; ovf = 1'b1;
        end else if (s < OUT_MIN) begin
            res = OUT_MIN; ovf = 1'b1;
        end else begin
            res = s; ovf = 1'b0;
        end
    endfunction

    // Present one vector, wait for it to be taken, then scramble the inputs.
    task automatic applyStimulus(input vec_t px, input vec_t wt, input logic [7:0] b,
                                 input logic [4:0] sh, input logic re);
        int w;
        @(negedge clk);
        pixels = px; weights = wt; bias = b; shift = sh; relu_en = re;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("accept_ready", in_ready, 1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        pixels  = {$urandom, $urandom};
        weights = {$urandom, $urandom};
        bias    = 8'($urandom);
        shift   = 5'($urandom);
        relu_en = 1'($urandom);
    endtask

    task automatic expectResult(input string tag, input longint exp_res, input longint exp_ovf);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, "_latency"}, cyc - accept_cyc, 4);
        checkOutput({tag, "_result"}, $signed(result), exp_res);
        checkOutput({tag, "_overflow"}, overflow, exp_ovf);
    endtask

    task automatic releaseOutput(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_valid_drop"}, out_valid, 0);
    endtask

    // Randomized runs on two other lane/width configurations, each with its
    // own reset so they are unaffected by the directed reset test.
    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int L = (g == 0) ? 1 : 4;
        localparam int N = (g == 0) ? 8 : 16;
        localparam int K = N / L;

        logic              g_rst, g_in_valid, g_in_ready, g_relu;
        logic              g_out_valid, g_out_ready, g_ovf;
        logic [N-1:0][7:0] g_pix, g_wt;
        logic [7:0]        g_bias, g_res;
        logic [4:0]        g_shift;
        logic              done;

        fc_neuron_seq #(.LANES(L), .N_IN(N)) dut_r (
            .clk       (clk),
            .rst       (g_rst),
            .in_valid  (g_in_valid),
            .in_ready  (g_in_ready),
            .pixels    (g_pix),
            .weights   (g_wt),
            .bias      (g_bias),
            .shift     (g_shift),
            .relu_en   (g_relu),
            .out_valid (g_out_valid),
            .out_ready (g_out_ready),
            .result    (g_res),
            .overflow  (g_ovf)
        );

        initial begin : rand_run
            longint pm[16];
            longint wm[16];
            longint er;
            bit     eo;
            int     lat;
            int     w;
            done = 1'b0;
            g_rst = 1'b1; g_in_valid = 1'b0; g_out_ready = 1'b0;
            g_pix = '0; g_wt = '0; g_bias = '0; g_shift = '0; g_relu = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            g_rst = 1'b0;
            for (int v = 0; v < 12; v++) begin
                @(negedge clk);
                for (int i = 0; i < 16; i++) begin
                    pm[i] = 0;
                    wm[i] = 0;
                end
                for (int i = 0; i < N; i++) begin
                    g_pix[i] = 8'($urandom);
                    g_wt[i]  = 8'($urandom);
                    pm[i]    = longint'(g_pix[i]);
                    wm[i]    = longint'($signed(g_wt[i]));
                end
                g_bias  = 8'($urandom);
                g_shift = 5'($urandom_range(0, 14));
                g_relu  = 1'($urandom);
                refModel(pm, wm, N, longint'($signed(g_bias)), int'(g_shift), g_relu, er, eo);
                g_in_valid = 1'b1;
                w = 0;
                while (!g_in_ready && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                checkOutput($sformatf("cfg%0d_v%0d_ready", g, v), g_in_ready, 1);
                @(posedge clk);
                #1;
                g_in_valid = 1'b0;
                for (int i = 0; i < N; i++) begin
                    g_pix[i] = 8'($urandom);
                    g_wt[i]  = 8'($urandom);
                end
                lat = 0;
                while (!g_out_valid && lat < 100) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                checkOutput($sformatf("cfg%0d_v%0d_latency", g, v), lat, K);
                checkOutput($sformatf("cfg%0d_v%0d_result", g, v), $signed(g_res), er);
                checkOutput($sformatf("cfg%0d_v%0d_overflow", g, v), g_ovf, eo);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                @(negedge clk);
                g_out_ready = 1'b1;
                @(posedge clk);
                #1;
                g_out_ready = 1'b0;
                checkOutput($sformatf("cfg%0d_v%0d_valid_drop", g, v), g_out_valid, 0);
            end
            done = 1'b1;
        end
    end

    // Directed sequence on the default configuration.
    initial begin
        vec_t ones, ramp, p255, w127, p10, wm1;
        int   n;
        ones = '0; ramp = '0; p255 = '0; w127 = '0; p10 = '0; wm1 = '0;
        for (int i = 0; i < 8; i++) begin
            ones[i] = 8'd1;
            ramp[i] = 8'(i + 1);
            p255[i] = 8'd255;
            w127[i] = 8'd127;
            p10[i]  = 8'd10;
            wm1[i]  = 8'hFF;
        end

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        pixels = '0; weights = '0; bias = '0; shift = '0; relu_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_result", $signed(result), 0);
        checkOutput("reset_overflow", overflow, 0);
        checkOutput("reset_in_ready", in_ready, 1);

        // Basic dot product; a vector offered during ACC must be ignored.
        applyStimulus(ones, ramp, 8'd0, 5'd0, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        checkOutput("acc_in_ready", in_ready, 0);
        @(negedge clk);
        checkOutput("acc_in_ready2", in_ready, 0);
        in_valid = 1'b0;
        expectResult("ramp", 36, 0);
        releaseOutput("ramp");

        // Positive saturation, then the same vector brought in range by shift.
        applyStimulus(p255, w127, 8'd0, 5'd0, 1'b0);
        expectResult("sat_pos", 127, 1);
        releaseOutput("sat_pos");
        applyStimulus(p255, w127, 8'd0, 5'd12, 1'b0);
        expectResult("shift12", 63, 0);
        releaseOutput("shift12");

        // Negative result with bias, then ReLU clamping it to zero.
        applyStimulus(p10, wm1, 8'd5, 5'd0, 1'b0);
        expectResult("neg", -75, 0);
        releaseOutput("neg");
        applyStimulus(p10, wm1, 8'd5, 5'd0, 1'b1);
        expectResult("relu", 0, 0);
        releaseOutput("relu");

        // Back-pressure: output held while out_ready is low, then a new
        // vector taken on the same edge as the output handshake.
        applyStimulus(ones, ramp, 8'd0, 5'd0, 1'b0);
        expectResult("hold", 36, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold%0d_valid", i), out_valid, 1);
            checkOutput($sformatf("hold%0d_result", i), $signed(result), 36);
            checkOutput($sformatf("hold%0d_overflow", i), overflow, 0);
            checkOutput($sformatf("hold%0d_in_ready", i), in_ready, 0);
        end
        @(negedge clk);
        pixels = p10; weights = wm1; bias = 8'd5; shift = 5'd0; relu_en = 1'b0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("b2b_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        in_valid = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b_valid_drop", out_valid, 0);
        expectResult("b2b", -75, 0);
        releaseOutput("b2b");

        // Reset in the middle of accumulation discards the vector.
        applyStimulus(p255, w127, 8'd0, 5'd0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_result", $signed(result), 0);
        checkOutput("midrst_overflow", overflow, 0);
        checkOutput("midrst_in_ready", in_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("midrst_no_stale", out_valid, 0);
        applyStimulus(ones, ramp, 8'd0, 5'd0, 1'b0);
        expectResult("after_rst", 36, 0);
        releaseOutput("after_rst");

        n = 0;
        while (!(cfg[0].done && cfg[1].done) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        checkOutput("random_runs_done", cfg[0].done && cfg[1].done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
